// File: rtl/nfca_tx_framer.sv
// ISO14443-A transmit framer: buffers a byte frame from AXI-Stream, then
// serialises S / data+parity / CRC_A / E bits one per downstream tx_req.
module nfca_tx_framer #(
  parameter int          AW       = 12,
  parameter logic [15:0] CRC_INIT = 16'h6363
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic [3:0] tx_tdatab,
  input  logic       tx_tlast,
  input  logic [1:0] crc_mode,
  input  logic       abort,
  input  logic       tx_req,
  output logic       tx_en,
  output logic       tx_bit,
  output logic [2:0] remainb,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_SOF, S_LOAD, S_SHIFT, S_CRC, S_EOF, S_DRAIN
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [7:0] ch;
    ch = d ^ crc[7:0];
    ch = ch ^ {ch[3:0], 4'h0};
    return {8'h00, crc[15:8]} ^ {ch, 8'h00} ^ {5'd0, ch, 3'd0} ^ {12'd0, ch[7:4]};
  endfunction

  function automatic logic is_short(input logic [7:0] b);
    return (b == 8'h26) || (b == 8'h52) || (b == 8'h35) ||
           (b[7:4] == 4'h4) || (b[7:3] == 5'b01111);
  endfunction

  function automatic logic [3:0] clamp_lastb(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'd8)  return 4'd8;
    return n;
  endfunction

  state_t        state_q, state_d;
  logic          tready_q, tready_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_bit_q, tx_bit_d;
  logic [2:0]    remainb_q, remainb_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [15:0]   crc_q, crc_d;
  logic [1:0]    mode_q, mode_d;
  logic          short_q, short_d;
  logic          auto_q, auto_d;
  logic [3:0]    lastb_q, lastb_d;
  logic          incomp_q, incomp_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [17:0]   shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    mem_q [2**AW];

  logic beat, wr_en, crc_on, load_eof, last_idx;

  always_comb begin
    state_d      = state_q;
    tready_d     = tready_q;
    tx_en_d      = tx_en_q;
    tx_bit_d     = tx_bit_q;
    remainb_d    = remainb_q;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    crc_d        = crc_q;
    mode_d       = mode_q;
    short_d      = short_q;
    auto_d       = auto_q;
    lastb_d      = lastb_q;
    incomp_d     = incomp_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    rdata_d      = mem_q[rptr_q];
    wr_en        = 1'b0;
    load_eof     = 1'b0;
    beat         = tx_tvalid & tready_q;
    last_idx     = (rptr_q == wptr_q - PTR_ONE);
    // Short frames and incomplete last bytes never carry CRC, whatever the mode.
    crc_on       = !short_q && !incomp_q &&
                   ((mode_q == 2'b01) || ((mode_q != 2'b10) && auto_q));

    if (abort) begin
      state_d  = S_ACCEPT;
      tready_d = 1'b1;
      tx_en_d  = 1'b0;
      tx_bit_d = 1'b0;
      wptr_d   = '0;
      rptr_d   = '0;
      crc_d    = CRC_INIT;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_req) begin
            state_d  = S_ACCEPT;
            tready_d = 1'b1;
          end
        end
        S_ACCEPT: begin
          if (beat) begin
            if (!(&wptr_q)) begin
              wr_en   = 1'b1;
              wptr_d  = wptr_q + PTR_ONE;
              crc_d   = crc_a_byte(crc_q, tx_tdata);
              lastb_d = clamp_lastb(tx_tdatab);
              if (wptr_q == '0) begin
                mode_d  = crc_mode;
                short_d = is_short(tx_tdata);
                auto_d  = !((tx_tdata == 8'h93) || (tx_tdata == 8'h95) || (tx_tdata == 8'h97));
              end else if ((wptr_q == PTR_ONE) && (tx_tdata == 8'h70)) begin
                auto_d = 1'b1;
              end
              if (tx_tlast) begin
                state_d  = S_SOF;
                tready_d = 1'b0;
                shift_d  = '0;
                bitcnt_d = 5'd1;
                rptr_d   = '0;
                incomp_d = 1'b0;
              end
            end else if (tx_tlast) begin
              overflow_d = 1'b1;
              wptr_d     = '0;
              rptr_d     = '0;
              crc_d      = CRC_INIT;
            end
          end
        end
        S_LOAD: begin
          rptr_d  = rptr_q + PTR_ONE;
          state_d = S_SHIFT;
          if ((rptr_q == '0) && short_q) begin
            shift_d  = {11'd0, rdata_q[6:0]};
            bitcnt_d = 5'd7;
          end else if ((rptr_q != '0) && last_idx && (lastb_q < 4'd8)) begin
            shift_d  = {10'd0, rdata_q};
            bitcnt_d = {1'b0, lastb_q};
            incomp_d = 1'b1;
          end else begin
            shift_d  = {9'd0, ~^rdata_q, rdata_q};
            bitcnt_d = 5'd9;
          end
        end
        S_SOF, S_SHIFT, S_CRC, S_EOF: begin
          if (bitcnt_q != 5'd0) begin
            if (tx_req) begin
              tx_en_d  = 1'b1;
              tx_bit_d = shift_q[0];
              shift_d  = {1'b0, shift_q[17:1]};
              bitcnt_d = bitcnt_q - 5'd1;
            end
          end else begin
            case (state_q)
              S_SOF:   state_d = S_LOAD;
              S_SHIFT: begin
                if (rptr_q != wptr_q) begin
                  state_d = S_LOAD;
                end else if (crc_on) begin
                  state_d  = S_CRC;
                  shift_d  = {~^crc_q[15:8], crc_q[15:8], ~^crc_q[7:0], crc_q[7:0]};
                  bitcnt_d = 5'd18;
                end else begin
                  load_eof = 1'b1;
                end
              end
              S_CRC:   load_eof = 1'b1;
              default: state_d = S_DRAIN;
            endcase
          end
          if (load_eof) begin
            state_d   = S_EOF;
            shift_d   = '0;
            bitcnt_d  = 5'd1;
            remainb_d = incomp_q ? lastb_q[2:0] : 3'd0;
          end
        end
        S_DRAIN: begin
          if (tx_req) begin
            state_d      = S_ACCEPT;
            tready_d     = 1'b1;
            tx_en_d      = 1'b0;
            tx_bit_d     = 1'b0;
            wptr_d       = '0;
            rptr_d       = '0;
            crc_d        = CRC_INIT;
            frame_done_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      tready_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_bit_q     <= 1'b0;
      remainb_q    <= 3'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      crc_q        <= CRC_INIT;
      mode_q       <= 2'b00;
      short_q      <= 1'b0;
      auto_q       <= 1'b1;
      lastb_q      <= 4'd8;
      incomp_q     <= 1'b0;
      bitcnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      tx_en_q      <= tx_en_d;
      tx_bit_q     <= tx_bit_d;
      remainb_q    <= remainb_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      crc_q        <= crc_d;
      mode_q       <= mode_d;
      short_q      <= short_d;
      auto_q       <= auto_d;
      lastb_q      <= lastb_d;
      incomp_q     <= incomp_d;
      bitcnt_q     <= bitcnt_d;
    end
  end

  // Frame buffer and its one-cycle read register carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= tx_tdata;
    rdata_q <= rdata_d;
    shift_q <= shift_d;
  end

  assign tx_tready  = tready_q;
  assign tx_en      = tx_en_q;
  assign tx_bit     = tx_bit_q;
  assign remainb    = remainb_q;
  assign busy       = (state_q != S_ACCEPT);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nfca_tx_framer.sv
// Directed bench for nfca_tx_framer: frames are pushed byte by byte and the
// serial bits are collected one tx_req pulse at a time against hand values.
module tb_nfca_tx_framer;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_tvalid = 1'b0;
  logic       tx_tready;
  logic [7:0] tx_tdata = 8'h00;
  logic [3:0] tx_tdatab = 4'd8;
  logic       tx_tlast = 1'b0;
  logic [1:0] crc_mode = 2'b00;
  logic       abort = 1'b0;
  logic       tx_req = 1'b0;
  logic       tx_en, tx_bit;
  logic [2:0] remainb;
  logic       busy, frame_done, overflow;

  int errors = 0;
  int checks = 0;
  logic [63:0] rx_bits;
  int          rx_n;
  logic        rx_done;

  nfca_tx_framer #(.AW(4), .CRC_INIT(16'h6363)) dut (
    .clk(clk), .rstn(rstn),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tdatab(tx_tdatab), .tx_tlast(tx_tlast), .crc_mode(crc_mode),
    .abort(abort), .tx_req(tx_req), .tx_en(tx_en), .tx_bit(tx_bit),
    .remainb(remainb), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic [3:0] db, input logic [1:0] m);
    int t;
    tx_tvalid = 1'b1; tx_tdata = d; tx_tlast = l; tx_tdatab = db; crc_mode = m;
    t = 0;
    while (tx_tready !== 1'b1 && t < 50) begin tick(); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: tready=%b want 1", tx_tready);
    end
    tick();
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [23:0] bytes, input logic [3:0] db, input logic [1:0] m);
    for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8], (i == n - 1), db, m);
  endtask

  task automatic run_frame(input int max_bits);
    rx_bits = '0; rx_n = 0; rx_done = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (rx_done || rx_n >= max_bits) break;
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      if (frame_done === 1'b1) rx_done = 1'b1;
      else if (tx_en === 1'b1 && rx_n < 64) begin rx_bits[rx_n] = tx_bit; rx_n++; end
      if (!rx_done) repeat (3) tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (tx_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", tx_tready); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    checks++; if (tx_bit !== 1'b0) begin errors++; $display("FAIL rst_tx_bit: got %b want 0", tx_bit); end
    checks++; if (remainb !== 3'd0) begin errors++; $display("FAIL rst_remainb: got %0d want 0", remainb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    rstn = 1'b1; tick();
    checks++; if (tx_tready !== 1'b0) begin errors++; $display("FAIL idle_tready: got %b want 0", tx_tready); end
    tx_req = 1'b1; tick(); tx_req = 1'b0;
    checks++; if (tx_tready !== 1'b1) begin errors++; $display("FAIL accept_tready: got %b want 1", tx_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy: got %b want 0", busy); end
  endtask

  task automatic test_short();
    send_frame(1, 24'h000026, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_done !== 1'b1) begin errors++; $display("FAIL short_done: got %b want 1", rx_done); end
    checks++; if (rx_n !== 9) begin errors++; $display("FAIL short_nbits: got %0d want 9", rx_n); end
    checks++; if (rx_bits[8:0] !== 9'h04C) begin errors++; $display("FAIL short_bits: got %h want 04c", rx_bits[8:0]); end
    checks++; if (remainb !== 3'd0) begin errors++; $display("FAIL short_remainb: got %0d want 0", remainb); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL short_done_pulse: got %b want 0", frame_done); end
    checks++; if (tx_tready !== 1'b1) begin errors++; $display("FAIL short_tready: got %b want 1", tx_tready); end
    send_frame(1, 24'h00004A, 4'd8, 2'b01);
    run_frame(100);
    checks++; if (rx_n !== 9 || rx_done !== 1'b1) begin errors++; $display("FAIL short_4x_nbits: got %0d done %b want 9 done 1", rx_n, rx_done); end
  endtask

  task automatic test_auto_crc();
    send_frame(2, 24'h002093, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 20) begin errors++; $display("FAIL auto93_nbits: got %0d want 20", rx_n); end
    checks++; if (rx_bits[19:0] !== 20'h08326) begin errors++; $display("FAIL auto93_bits: got %h want 08326", rx_bits[19:0]); end
    send_frame(2, 24'h002093, 4'd8, 2'b01);
    run_frame(100);
    checks++; if (rx_n !== 38) begin errors++; $display("FAIL force93_nbits: got %0d want 38", rx_n); end
    send_frame(2, 24'h000050, 4'd8, 2'b10);
    run_frame(100);
    checks++; if (rx_n !== 20) begin errors++; $display("FAIL suppress50_nbits: got %0d want 20", rx_n); end
    send_frame(2, 24'h007093, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 38) begin errors++; $display("FAIL sel70_nbits: got %0d want 38", rx_n); end
  endtask

  task automatic test_crc_value();
    send_frame(2, 24'h000050, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 38) begin errors++; $display("FAIL crc_nbits: got %0d want 38", rx_n); end
    checks++; if (rx_bits[9] !== 1'b1) begin errors++; $display("FAIL crc_par50: got %b want 1", rx_bits[9]); end
    checks++; if (rx_bits[26:19] !== 8'h57) begin errors++; $display("FAIL crc_lo: got %h want 57", rx_bits[26:19]); end
    checks++; if (rx_bits[27] !== 1'b0) begin errors++; $display("FAIL crc_lo_par: got %b want 0", rx_bits[27]); end
    checks++; if (rx_bits[35:28] !== 8'hCD) begin errors++; $display("FAIL crc_hi: got %h want cd", rx_bits[35:28]); end
    checks++; if (rx_bits[37:36] !== 2'b00) begin errors++; $display("FAIL crc_hi_par_eof: got %b want 00", rx_bits[37:36]); end
  endtask

  task automatic test_partial();
    send_frame(3, 24'h032293, 4'd2, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 22) begin errors++; $display("FAIL part_nbits: got %0d want 22", rx_n); end
    checks++; if (rx_bits[21:19] !== 3'b011) begin errors++; $display("FAIL part_tail: got %b want 011", rx_bits[21:19]); end
    checks++; if (remainb !== 3'd2) begin errors++; $display("FAIL part_remainb: got %0d want 2", remainb); end
  endtask

  task automatic test_abort();
    int fd;
    send_frame(2, 24'h000050, 4'd8, 2'b00);
    run_frame(22);
    checks++; if (rx_n !== 22) begin errors++; $display("FAIL abort_pre_nbits: got %0d want 22", rx_n); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL abort_tx_en: got %b want 0", tx_en); end
    checks++; if (tx_bit !== 1'b0) begin errors++; $display("FAIL abort_tx_bit: got %b want 0", tx_bit); end
    checks++; if (tx_tready !== 1'b1) begin errors++; $display("FAIL abort_tready: got %b want 1", tx_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (remainb !== 3'd2) begin errors++; $display("FAIL abort_remainb: got %0d want 2", remainb); end
    fd = 0;
    for (int i = 0; i < 3; i++) begin
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      if (frame_done === 1'b1) fd++;
      repeat (2) tick();
    end
    checks++; if (fd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", fd); end
    send_frame(2, 24'h000050, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_bits[26:19] !== 8'h57 || rx_bits[35:28] !== 8'hCD) begin
      errors++; $display("FAIL abort_next_crc: got %h %h want 57 cd", rx_bits[26:19], rx_bits[35:28]);
    end
    checks++; if (remainb !== 3'd0) begin errors++; $display("FAIL abort_next_remainb: got %0d want 0", remainb); end
  endtask

  task automatic test_abort_beat();
    tx_tvalid = 1'b1; tx_tdata = 8'h26; tx_tlast = 1'b1; abort = 1'b1;
    tick();
    tx_tvalid = 1'b0; tx_tlast = 1'b0; abort = 1'b0;
    checks++; if (tx_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_beat_state: got tready %b busy %b want 1 0", tx_tready, busy);
    end
    send_frame(1, 24'h000026, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 9) begin errors++; $display("FAIL abort_beat_nbits: got %0d want 9", rx_n); end
  endtask

  task automatic test_overflow();
    int ovf;
    logic en_seen, rdy_low;
    ovf = 0; en_seen = 1'b0; rdy_low = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h10 + 8'(i), (i == 16), 4'd8, 2'b00);
      if (overflow === 1'b1) ovf++;
      if (tx_en === 1'b1) en_seen = 1'b1;
      if (tx_tready !== 1'b1) rdy_low = 1'b1;
    end
    tick();
    if (overflow === 1'b1) ovf++;
    checks++; if (ovf !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf); end
    checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL ovf_tx_en: got %b want 0", en_seen); end
    checks++; if (rdy_low !== 1'b0 || tx_tready !== 1'b1) begin errors++; $display("FAIL ovf_tready: got %b want 1", tx_tready); end
    send_frame(2, 24'h002093, 4'd8, 2'b00);
    run_frame(100);
    checks++; if (rx_n !== 20 || rx_bits[19:0] !== 20'h08326) begin
      errors++; $display("FAIL ovf_next: got %0d bits %h want 20 bits 08326", rx_n, rx_bits[19:0]);
    end
  endtask

  task automatic test_reset_midframe();
    int en_cnt, fd;
    send_frame(2, 24'h000050, 4'd8, 2'b00);
    run_frame(5);
    rstn = 1'b0; #1;
    checks++; if (tx_en !== 1'b0 || tx_tready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_outputs: got en %b rdy %b busy %b want 0 0 1", tx_en, tx_tready, busy);
    end
    tick(); rstn = 1'b1; tick();
    en_cnt = 0; fd = 0;
    for (int i = 0; i < 4; i++) begin
      tx_req = 1'b1; tick(); tx_req = 1'b0;
      if (tx_en === 1'b1) en_cnt++;
      if (frame_done === 1'b1) fd++;
      repeat (2) tick();
    end
    checks++; if (en_cnt !== 0 || fd !== 0) begin errors++; $display("FAIL midrst_bits: got en %0d done %0d want 0 0", en_cnt, fd); end
    checks++; if (tx_tready !== 1'b1) begin errors++; $display("FAIL midrst_tready: got %b want 1", tx_tready); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_auto_crc();
    test_crc_value();
    test_partial();
    test_abort();
    test_abort_beat();
    test_overflow();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
